nn_fetch_engine: RTL and testbench

- Parametrised successor to the fixed-size image/coefficient loader used by the neural-network datapath.
- On a get_image or get_coeffs request for a given layer, issues pipelined Avalon-MM reads from SDRAM and streams the returned words into the local image or coefficient buffer through a write port.
- Generalised in bus width, buffer sizes, layer count, layer address stride and read depth (maximum outstanding reads).
- Reports busy and a one-cycle done pulse.

---
 rtl/nn_fetch_pkg.sv | 21 ++
 rtl/nn_read_tracker.sv | 58 +++++
 rtl/nn_fetch_engine.sv | 171 +++++++++++++++++
 tb/tb_nn_fetch_engine.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_fetch_pkg.sv
// Shared types and helpers for the neural-network SDRAM fetch engine.
package nn_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  typedef enum logic {
    TGT_IMAGE = 1'b0,
    TGT_COEFF = 1'b1
  } target_t;

  // Number of bus words needed to cover one region of a layer.
  function automatic int words_per_region(input int region_bytes, input int data_bytes);
    return region_bytes / data_bytes;
  endfunction

endpackage

// File: rtl/nn_read_tracker.sv
// Tracks reads issued, reads in flight and responses received for one fetch,
// and flags when another read may be issued and when every word is back.
module nn_read_tracker #(
  parameter int CNT_W           = 10,
  parameter int IDX_W           = 9,
  parameter int OUT_W           = 3,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             active,
  input  logic             rd_accept,
  input  logic             rsp_valid,
  input  logic [CNT_W-1:0] words,
  output logic [CNT_W-1:0] issued,
  output logic [IDX_W-1:0] received_idx,
  output logic             issue_en,
  output logic             last_issue,
  output logic             rsp_accept,
  output logic             all_received
);

  logic [CNT_W-1:0] received;
  logic [OUT_W-1:0] outstanding;

  // A response only counts while a fetch is running and a read is really in
  // flight; anything else is a stray strobe and must not underflow the count.
  always_comb begin
    rsp_accept   = active && rsp_valid && (outstanding != '0);
    issue_en     = (issued < words) && (outstanding < OUT_W'(MAX_OUTSTANDING));
    last_issue   = rd_accept && (issued == (words - CNT_W'(1)));
    all_received = (received == words);
    received_idx = received[IDX_W-1:0];
  end

  // Counter state; cleared at the start of every fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
    end else if (clear) begin
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
    end else begin
      if (rd_accept) issued <= issued + CNT_W'(1);
      if (rsp_accept) received <= received + CNT_W'(1);
      case ({rd_accept, rsp_accept})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: rtl/nn_fetch_engine.sv
// Loads one layer's image or coefficient region from SDRAM over pipelined
// Avalon-MM reads and streams the words into the local buffer write port.
module nn_fetch_engine
  import nn_fetch_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_BYTES      = 4,
  parameter int                IMSIZE          = 64,
  parameter int                CSIZE           = 2048,
  parameter int                LBITS           = 2,
  parameter logic [ADDR_W-1:0] IMG_BASE        = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] COEFF_BASE      = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] LAYER_STRIDE    = 32'h0000_0800,
  parameter int                MAX_OUTSTANDING = 4
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 get_image,
  input  logic                                 get_coeffs,
  input  logic [LBITS-1:0]                     layer,
  output logic                                 busy,
  output logic                                 done,
  output logic [ADDR_W-1:0]                    avm_address,
  output logic                                 avm_read,
  input  logic                                 avm_waitrequest,
  input  logic [8*DATA_BYTES-1:0]              avm_readdata,
  input  logic                                 avm_readdatavalid,
  output logic                                 wr_en,
  output logic                                 wr_target,
  output logic [$clog2(CSIZE/DATA_BYTES)-1:0]  wr_addr,
  output logic [8*DATA_BYTES-1:0]              wr_data
);

  localparam int IMG_WORDS   = words_per_region(IMSIZE, DATA_BYTES);
  localparam int COEFF_WORDS = words_per_region(CSIZE, DATA_BYTES);
  localparam int IDX_W       = $clog2(COEFF_WORDS);
  localparam int CNT_W       = IDX_W + 1;
  localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam int DW          = 8 * DATA_BYTES;
  localparam int BYTE_SH     = $clog2(DATA_BYTES);

  fetch_state_t      state_q, state_d;
  target_t           tgt_q;
  logic [ADDR_W-1:0] start_q;
  logic [CNT_W-1:0]  words_q;

  logic              accept;
  target_t           req_tgt;
  logic [ADDR_W-1:0] req_start;
  logic [CNT_W-1:0]  req_words;
  logic              active;
  logic              rd_accept;

  logic [CNT_W-1:0]  issued;
  logic [IDX_W-1:0]  received_idx;
  logic              issue_en;
  logic              last_issue;
  logic              rsp_accept;
  logic              all_received;

  logic              vld_p1;
  target_t           tgt_p1;
  logic [IDX_W-1:0]  addr_p1;
  logic [DW-1:0]     data_p1;

  // Request decode; coefficients win when both requests arrive together.
  always_comb begin
    accept    = (state_q == IDLE) && (get_image || get_coeffs);
    req_tgt   = get_coeffs ? TGT_COEFF : TGT_IMAGE;
    req_start = (get_coeffs ? COEFF_BASE : IMG_BASE) + (ADDR_W'(layer) * LAYER_STRIDE);
    req_words = get_coeffs ? CNT_W'(COEFF_WORDS) : CNT_W'(IMG_WORDS);
    active    = (state_q == ISSUE) || (state_q == DRAIN);
    rd_accept = avm_read && !avm_waitrequest;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and state-derived bus/status outputs. Address and read only
  // depend on registered state, so they stay put while the slave stalls.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    avm_read    = 1'b0;
    avm_address = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        busy        = 1'b1;
        avm_read    = issue_en;
        avm_address = start_q + (ADDR_W'(issued) << BYTE_SH);
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (all_received) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch descriptor captured when a request is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tgt_q   <= TGT_IMAGE;
      start_q <= '0;
      words_q <= '0;
    end else if (accept) begin
      tgt_q   <= req_tgt;
      start_q <= req_start;
      words_q <= req_words;
    end
  end

  nn_read_tracker #(
    .CNT_W          (CNT_W),
    .IDX_W          (IDX_W),
    .OUT_W          (OUT_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_tracker (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (accept),
    .active      (active),
    .rd_accept   (rd_accept),
    .rsp_valid   (avm_readdatavalid),
    .words       (words_q),
    .issued      (issued),
    .received_idx(received_idx),
    .issue_en    (issue_en),
    .last_issue  (last_issue),
    .rsp_accept  (rsp_accept),
    .all_received(all_received)
  );

  // ---- stage p1: registered response becomes a buffer write ----
  // Write strobe is control and is cleared by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= rsp_accept;
  end

  // Write payload; only meaningful while vld_p1 is set.
  always_ff @(posedge clock) begin
    if (rsp_accept) begin
      tgt_p1  <= tgt_q;
      addr_p1 <= received_idx;
      data_p1 <= avm_readdata;
    end
  end

  // Payload is masked when idle so the port reads zero out of reset.
  always_comb begin
    wr_en     = vld_p1;
    wr_target = vld_p1 && (tgt_p1 == TGT_COEFF);
    wr_addr   = vld_p1 ? addr_p1 : '0;
    wr_data   = vld_p1 ? data_p1 : '0;
  end

endmodule

// File: tb/tb_nn_fetch_engine.sv
// Bench for nn_fetch_engine: two configurations (default, and 8-byte serial
// reads with a wrapping layer stride) each with an Avalon slave model and a
// write-port scoreboard.
module tb_nn_fetch_engine;

  int   errors = 0;
  int   checks = 0;
  logic clock  = 1'b0;
  bit   fin [2];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int          DB     = (g == 0) ? 4 : 8;
    localparam int          MAXO   = (g == 0) ? 4 : 1;
    localparam int          CSZ    = (g == 0) ? 2048 : 256;
    localparam logic [31:0] STRIDE = (g == 0) ? 32'h0000_0800 : 32'hFFFF_F000;
    localparam logic [31:0] IBASE  = 32'h0000_0000;
    localparam logic [31:0] CBASE  = 32'h0001_0000;
    localparam int          DW     = 8 * DB;
    localparam int          AW     = $clog2(CSZ / DB);

    logic          reset_n, get_image, get_coeffs;
    logic [1:0]    layer;
    logic          busy, done;
    logic [31:0]   avm_address;
    logic          avm_read, avm_waitrequest, avm_readdatavalid;
    logic [DW-1:0] avm_readdata;
    logic          wr_en, wr_target;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    nn_fetch_engine #(
      .ADDR_W(32), .DATA_BYTES(DB), .IMSIZE(64), .CSIZE(CSZ), .LBITS(2),
      .IMG_BASE(IBASE), .COEFF_BASE(CBASE), .LAYER_STRIDE(STRIDE),
      .MAX_OUTSTANDING(MAXO)
    ) dut (
      .clock(clock), .reset_n(reset_n), .get_image(get_image),
      .get_coeffs(get_coeffs), .layer(layer), .busy(busy), .done(done),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .wr_en(wr_en),
      .wr_target(wr_target), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    logic          exp_tgt [$];
    int            exp_idx [$];
    logic [DW-1:0] exp_dat [$];
    logic [31:0]   exp_rd  [$];
    logic [31:0]   pend_addr [$];
    int            pend_due  [$];
    int            cyc, stall_pct, lat, inflight, wr_count, done_cnt;
    bit            spur_req, prev_stall, prev_done;
    logic [31:0]   prev_addr;

    // Memory contents as a pure function of the byte address.
    function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
      logic [63:0] w;
      w = {a ^ 32'hC3C3_0000, a * 32'h9E37_79B1 + 32'h0000_1234};
      return w[DW-1:0];
    endfunction

    // Reference model: a fetch reads consecutive words from base+layer*stride.
    task automatic push_fetch(input bit coef, input int lay);
      logic [31:0] s;
      int n;
      s = (coef ? CBASE : IBASE) + STRIDE * lay;
      n = (coef ? CSZ : 64) / DB;
      for (int i = 0; i < n; i++) begin
        exp_rd.push_back(s + i * DB);
        exp_tgt.push_back(coef);
        exp_idx.push_back(i);
        exp_dat.push_back(mem_word(s + i * DB));
      end
    endtask

    task automatic wait_done(input int d0);
      for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge clock);
      checks++;
      if (done_cnt == d0) begin
        errors++;
        $display("FAIL done_timeout[%0d] done_cnt=%0d required>%0d", g, done_cnt, d0);
      end
    endtask

    task automatic fetch(input bit img, input bit coef, input int lay, input int st, input int lt);
      int d0;
      stall_pct = st;
      lat = lt;
      d0 = done_cnt;
      push_fetch(coef, lay);
      @(negedge clock);
      get_image = img; get_coeffs = coef; layer = lay[1:0];
      @(negedge clock);
      get_image = 1'b0; get_coeffs = 1'b0;
      wait_done(d0);
    endtask

    // Avalon slave: random stalls, fixed in-order latency, optional stray strobe.
    initial begin
      logic [31:0] e;
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
      cyc = 0; inflight = 0; prev_stall = 1'b0; prev_addr = '0;
      forever begin
        @(negedge clock);
        cyc++;
        if (prev_stall) begin
          checks++;
          if (!(avm_read && avm_address == prev_addr)) begin
            errors++;
            $display("FAIL hold[%0d] read=%0b addr=%h required read=1 addr=%h", g, avm_read, avm_address, prev_addr);
          end
        end
        avm_waitrequest = ($urandom_range(99) < stall_pct);
        prev_stall = avm_read && avm_waitrequest;
        prev_addr  = avm_address;
        if (avm_read && !avm_waitrequest) begin
          checks++;
          if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL read_addr[%0d] got=%h required=none", g, avm_address);
          end else begin
            e = exp_rd.pop_front();
            if (avm_address !== e) begin
              errors++;
              $display("FAIL read_addr[%0d] got=%h required=%h", g, avm_address, e);
            end
          end
          pend_addr.push_back(avm_address);
          pend_due.push_back(cyc + lat);
          inflight++;
          checks++;
          if (inflight > MAXO) begin
            errors++;
            $display("FAIL inflight[%0d] got=%0d required<=%0d", g, inflight, MAXO);
          end
        end
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        if (spur_req) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = '1;
          spur_req = 1'b0;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = mem_word(pend_addr.pop_front());
          void'(pend_due.pop_front());
          inflight--;
        end
      end
    end

    // Monitor: compare every buffer write and done pulse against the scoreboard.
    initial begin
      logic          t;
      int            ix;
      logic [DW-1:0] d;
      wr_count = 0; done_cnt = 0; prev_done = 1'b0;
      forever begin
        @(negedge clock);
        if (prev_done) begin
          checks++;
          if (busy) begin
            errors++;
            $display("FAIL busy_after_done[%0d] busy=%0b required=0", g, busy);
          end
        end
        prev_done = done;
        if (wr_en) begin
          checks++;
          wr_count++;
          if (exp_idx.size() == 0) begin
            errors++;
            $display("FAIL write[%0d] unexpected addr=%0d data=%h required=no write", g, wr_addr, wr_data);
          end else begin
            t = exp_tgt.pop_front(); ix = exp_idx.pop_front(); d = exp_dat.pop_front();
            if (wr_target !== t || wr_addr !== AW'(ix) || wr_data !== d) begin
              errors++;
              $display("FAIL write[%0d] got tgt=%0b addr=%0d data=%h required tgt=%0b addr=%0d data=%h",
                       g, wr_target, wr_addr, wr_data, t, ix, d);
            end
          end
        end
        if (done) begin
          done_cnt++;
          checks++;
          if (exp_idx.size() != 0) begin
            errors++;
            $display("FAIL done_early[%0d] writes_left=%0d required=0", g, exp_idx.size());
          end
        end
      end
    end

    // Stimulus sequence for this configuration.
    initial begin
      int d0, w0;
      bit hit;
      reset_n = 1'b0; get_image = 1'b0; get_coeffs = 1'b0; layer = '0;
      stall_pct = 0; lat = 3; spur_req = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if ({busy, done, avm_read, wr_en, wr_target} != 5'b0 || avm_address != 0 || wr_addr != 0 || wr_data != 0) begin
        errors++;
        $display("FAIL reset_state[%0d] busy=%0b done=%0b read=%0b wr_en=%0b addr=%h required all zero",
                 g, busy, done, avm_read, wr_en, avm_address);
      end
      reset_n = 1'b1;
      @(negedge clock);
      if (g == 0) begin
        fetch(1'b1, 1'b0, 2, 0, 3);

        stall_pct = 50; lat = 3; d0 = done_cnt;
        push_fetch(1'b1, 1);
        @(negedge clock); get_coeffs = 1'b1; layer = 2'd1;
        @(negedge clock); get_coeffs = 1'b0;
        repeat (40) @(negedge clock);
        get_image = 1'b1; layer = 2'd3;
        @(negedge clock); get_image = 1'b0;
        wait_done(d0);
        repeat (3) @(negedge clock);
        checks++;
        if (busy || avm_read) begin
          errors++;
          $display("FAIL dropped_req[%0d] busy=%0b read=%0b required 0 0", g, busy, avm_read);
        end

        fetch(1'b1, 1'b1, 0, 10, 2);

        stall_pct = 20; lat = 3; d0 = done_cnt; w0 = wr_count;
        push_fetch(1'b1, 3);
        @(negedge clock); get_coeffs = 1'b1; layer = 2'd3;
        @(negedge clock); get_coeffs = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
          @(negedge clock); #1;
          if (wr_count - w0 >= 100) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
          errors++;
          $display("FAIL reset_wait[%0d] writes=%0d required>=100", g, wr_count - w0);
        end
        #1 reset_n = 1'b0;
        exp_rd.delete(); exp_tgt.delete(); exp_idx.delete(); exp_dat.delete();
        prev_stall = 1'b0;
        #1;
        checks++;
        if ({busy, done, avm_read, wr_en} != 4'b0 || avm_address != 0 || wr_data != 0) begin
          errors++;
          $display("FAIL async_reset[%0d] busy=%0b done=%0b read=%0b wr_en=%0b required all zero",
                   g, busy, done, avm_read, wr_en);
        end
        stall_pct = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 50 && pend_due.size() != 0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        checks++;
        if (done_cnt != d0) begin
          errors++;
          $display("FAIL reset_no_done[%0d] done_cnt=%0d required=%0d", g, done_cnt, d0);
        end

        stall_pct = 0; lat = 3; d0 = done_cnt;
        push_fetch(1'b0, 1);
        @(negedge clock); get_image = 1'b1; layer = 2'd1;
        #1 spur_req = 1'b1;
        @(negedge clock); get_image = 1'b0;
        wait_done(d0);

        repeat (5) @(negedge clock);
        checks++;
        if (done_cnt != 4) begin
          errors++;
          $display("FAIL done_count[%0d] got=%0d required=4", g, done_cnt);
        end
      end else begin
        fetch(1'b1, 1'b0, 3, 30, 2);
        fetch(1'b0, 1'b1, 1, 0, 4);
        repeat (5) @(negedge clock);
        checks++;
        if (done_cnt != 2) begin
          errors++;
          $display("FAIL done_count[%0d] got=%0d required=2", g, done_cnt);
        end
      end
      fin[g] = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 90000 && !(fin[0] && fin[1]); i++) @(negedge clock);
    checks++;
    if (!(fin[0] && fin[1])) begin
      errors++;
      $display("FAIL global_timeout fin0=%0b fin1=%0b required 1 1", fin[0], fin[1]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
